mem_wb_writeback: RTL and testbench

- MEM/WB pipeline register plus writeback-select logic for the pipelined MIPS core.
- Captures the MEM-stage results and picks the write value: ALU result, load data, or link address.
- Drives the register-file write port of the decode stage: RegWrite, WriteRegister, WriteData and ALUMemOrPC.
- Adds stall/flush control, a valid bit, $zero write suppression and a retired-instruction counter.

---
 rtl/mem_wb_writeback_pkg.sv | 20 ++
 rtl/mem_wb_writeback_pipe_register.sv | 29 ++
 rtl/mem_wb_writeback.sv | 82 ++++++++
 tb/tb_mem_wb_writeback.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/mem_wb_writeback_pkg.sv
// Shared constants and helpers for the MEM/WB writeback stage.
package mem_wb_writeback_pkg;

  localparam int NBITS_DEF = 32;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC  = 2'd2;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_RA   = 5'd31;

  // Link wins over load so jal always writes its return address.
  function automatic logic [1:0] wb_select(input logic link, input logic memtoreg);
    if (link)          return WB_PC;
    else if (memtoreg) return WB_MEM;
    else               return WB_ALU;
  endfunction

endpackage

// File: rtl/mem_wb_writeback_pipe_register.sv
// Generic stage register: active-low synchronous reset, clear (bubble) beats enable.
module mem_wb_writeback_pipe_register #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] data_d;
  logic [W-1:0] data_q;

  always_comb begin
    data_d = data_q;
    if (clr)     data_d = '0;
    else if (en) data_d = d;
  end

  always_ff @(posedge clk) begin
    if (!reset) data_q <= '0;
    else        data_q <= data_d;
  end

  assign q = data_q;

endmodule

// File: rtl/mem_wb_writeback.sv
// MEM/WB pipeline register with writeback-source select, $zero write suppression
// and a retired-instruction counter.
module mem_wb_writeback
  import mem_wb_writeback_pkg::*;
#(
  parameter int NBits     = NBITS_DEF,
  parameter int CountBits = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 in_Valid,
  input  logic                 in_RegWrite,
  input  logic                 in_MemtoReg,
  input  logic                 in_ALUMemOrPC,
  input  logic [4:0]           in_WriteRegister,
  input  logic [NBits-1:0]     in_ALUResult,
  input  logic [NBits-1:0]     in_MemReadData,
  input  logic [NBits-1:0]     in_PCPlus4,
  output logic                 out_RegWrite,
  output logic [4:0]           out_WriteRegister,
  output logic [NBits-1:0]     out_WriteData,
  output logic                 out_ALUMemOrPC,
  output logic                 out_Valid,
  output logic [CountBits-1:0] RetiredCount
);

  localparam int BW = NBits + 8;

  logic [NBits-1:0] sel_data;
  logic             we;
  logic [BW-1:0]    bundle_d;
  logic [BW-1:0]    bundle_q;

  always_comb begin
    sel_data = in_ALUResult;
    case (wb_select(in_ALUMemOrPC, in_MemtoReg))
      WB_PC:   sel_data = in_PCPlus4;
      WB_MEM:  sel_data = in_MemReadData;
      default: sel_data = in_ALUResult;
    endcase
  end

  // jal to $zero still writes: decode redirects a link write to $ra.
  assign we = in_Valid & in_RegWrite &
              (in_ALUMemOrPC | (in_WriteRegister != REG_ZERO));

  assign bundle_d = {in_Valid, we, in_Valid & in_ALUMemOrPC, in_WriteRegister, sel_data};

  mem_wb_writeback_pipe_register #(.W(BW)) u_fields (
    .clk   (clk),
    .reset (reset),
    .en    (!stall),
    .clr   (flush),
    .d     (bundle_d),
    .q     (bundle_q)
  );

  assign out_Valid         = bundle_q[BW-1];
  assign out_RegWrite      = bundle_q[BW-2];
  assign out_ALUMemOrPC    = bundle_q[BW-3];
  assign out_WriteRegister = bundle_q[NBits+4:NBits];
  assign out_WriteData     = bundle_q[NBits-1:0];

  logic [CountBits-1:0] count_d;
  logic [CountBits-1:0] count_q;

  // Counted only on the edge that actually captures, so a stalled instruction counts once.
  always_comb begin
    count_d = count_q;
    if (!flush && !stall && in_Valid) count_d = count_q + CountBits'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end

  assign RetiredCount = count_q;

endmodule

// File: tb/tb_mem_wb_writeback.sv
// Directed bench for mem_wb_writeback, with a 4-bit-counter instance for wrap-around.
module tb_mem_wb_writeback;
  import mem_wb_writeback_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, flush;
  logic        in_Valid, in_RegWrite, in_MemtoReg, in_ALUMemOrPC;
  logic [4:0]  in_WriteRegister;
  logic [31:0] in_ALUResult, in_MemReadData, in_PCPlus4;

  logic        out_RegWrite, out_ALUMemOrPC, out_Valid;
  logic [4:0]  out_WriteRegister;
  logic [31:0] out_WriteData;
  logic [31:0] RetiredCount;

  logic        w4_RegWrite, w4_ALUMemOrPC, w4_Valid;
  logic [4:0]  w4_WriteRegister;
  logic [31:0] w4_WriteData;
  logic [3:0]  w4_RetiredCount;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mem_wb_writeback #(.NBits(32), .CountBits(32)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .in_Valid(in_Valid), .in_RegWrite(in_RegWrite), .in_MemtoReg(in_MemtoReg),
    .in_ALUMemOrPC(in_ALUMemOrPC), .in_WriteRegister(in_WriteRegister),
    .in_ALUResult(in_ALUResult), .in_MemReadData(in_MemReadData), .in_PCPlus4(in_PCPlus4),
    .out_RegWrite(out_RegWrite), .out_WriteRegister(out_WriteRegister),
    .out_WriteData(out_WriteData), .out_ALUMemOrPC(out_ALUMemOrPC),
    .out_Valid(out_Valid), .RetiredCount(RetiredCount)
  );

  mem_wb_writeback #(.NBits(32), .CountBits(4)) dut_w4 (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .in_Valid(in_Valid), .in_RegWrite(in_RegWrite), .in_MemtoReg(in_MemtoReg),
    .in_ALUMemOrPC(in_ALUMemOrPC), .in_WriteRegister(in_WriteRegister),
    .in_ALUResult(in_ALUResult), .in_MemReadData(in_MemReadData), .in_PCPlus4(in_PCPlus4),
    .out_RegWrite(w4_RegWrite), .out_WriteRegister(w4_WriteRegister),
    .out_WriteData(w4_WriteData), .out_ALUMemOrPC(w4_ALUMemOrPC),
    .out_Valid(w4_Valid), .RetiredCount(w4_RetiredCount)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
  endtask

  task automatic drive(input logic v, input logic rw, input logic mt, input logic link,
                       input logic [4:0] wreg, input logic [31:0] alu,
                       input logic [31:0] mrd, input logic [31:0] pc);
    in_Valid = v; in_RegWrite = rw; in_MemtoReg = mt; in_ALUMemOrPC = link;
    in_WriteRegister = wreg; in_ALUResult = alu; in_MemReadData = mrd; in_PCPlus4 = pc;
  endtask

  // Inputs settle before the edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic v, input logic rw, input logic link,
                           input logic [4:0] wreg, input logic [31:0] wdata,
                           input logic [31:0] cnt);
    check({tag, ".valid"}, 64'(out_Valid), 64'(v));
    check({tag, ".regwrite"}, 64'(out_RegWrite), 64'(rw));
    check({tag, ".link"}, 64'(out_ALUMemOrPC), 64'(link));
    check({tag, ".wreg"}, 64'(out_WriteRegister), 64'(wreg));
    check({tag, ".wdata"}, 64'(out_WriteData), 64'(wdata));
    check({tag, ".count"}, 64'(RetiredCount), 64'(cnt));
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; flush = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 5'd3, 32'h1, 32'h2, 32'h3);

    // Reset with random traffic on the inputs
    for (int i = 0; i < 2; i++) begin
      drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom),
            $urandom, $urandom, $urandom);
      stall = 1'($urandom);
      flush = 1'($urandom);
      step();
    end
    check_all("reset", 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'd0);
    check("reset.count4", 64'(w4_RetiredCount), 64'd0);

    reset = 1'b1; stall = 1'b0; flush = 1'b0;

    drive(1'b1, 1'b1, 1'b0, 1'b0, 5'd8, 32'h0000_0010, 32'h5555_5555, 32'h0000_1004);
    step();
    check_all("alu", 1'b1, 1'b1, 1'b0, 5'd8, 32'h0000_0010, 32'd1);

    drive(1'b1, 1'b1, 1'b1, 1'b0, 5'd9, 32'h0000_0020, 32'hDEAD_BEEF, 32'h0000_1008);
    step();
    check_all("load", 1'b1, 1'b1, 1'b0, 5'd9, 32'hDEAD_BEEF, 32'd2);

    // Link beats MemtoReg, and a jal to register 0 still writes
    drive(1'b1, 1'b1, 1'b1, 1'b1, REG_ZERO, 32'h0000_0030, 32'hCAFE_F00D, 32'h0040_0024);
    step();
    check_all("link", 1'b1, 1'b1, 1'b1, REG_ZERO, 32'h0040_0024, 32'd3);

    drive(1'b1, 1'b1, 1'b0, 1'b0, REG_ZERO, 32'h0000_0077, 32'h0, 32'h0);
    step();
    check_all("zero", 1'b1, 1'b0, 1'b0, REG_ZERO, 32'h0000_0077, 32'd4);

    drive(1'b0, 1'b1, 1'b0, 1'b1, 5'd5, 32'h0000_0099, 32'h0, 32'h0000_2000);
    step();
    check("bubble.valid", 64'(out_Valid), 64'd0);
    check("bubble.regwrite", 64'(out_RegWrite), 64'd0);
    check("bubble.link", 64'(out_ALUMemOrPC), 64'd0);
    check("bubble.count", 64'(RetiredCount), 64'd4);

    drive(1'b1, 1'b1, 1'b0, 1'b0, 5'd10, 32'h0000_AAAA, 32'h0, 32'h0);
    step();
    check_all("instr_a", 1'b1, 1'b1, 1'b0, 5'd10, 32'h0000_AAAA, 32'd5);

    drive(1'b1, 1'b1, 1'b0, 1'b0, 5'd11, 32'h0000_BBBB, 32'h0, 32'h0);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_all($sformatf("stall%0d", i), 1'b1, 1'b1, 1'b0, 5'd10, 32'h0000_AAAA, 32'd5);
    end
    stall = 1'b0;
    step();
    check_all("instr_b", 1'b1, 1'b1, 1'b0, 5'd11, 32'h0000_BBBB, 32'd6);

    stall = 1'b1; flush = 1'b1;
    step();
    check_all("stall_flush", 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'd6);

    stall = 1'b0; flush = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 1'b1, REG_RA, 32'h1, 32'h2, 32'h0000_3000);
    step();
    check_all("flush", 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'd6);

    flush = 1'b0;
    step();
    check_all("after_flush", 1'b1, 1'b1, 1'b1, REG_RA, 32'h0000_3000, 32'd7);

    // Reset wins over an active stall
    stall = 1'b1; reset = 1'b0;
    step();
    check_all("reset_mid_stall", 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'd0);

    reset = 1'b1; stall = 1'b0;
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, 5'(i + 1), 32'(i), 32'h0, 32'h0);
      step();
    end
    check("wrap.count4", 64'(w4_RetiredCount), 64'd1);
    check("wrap.count32", 64'(RetiredCount), 64'd17);
    check("wrap.wdata", 64'(w4_WriteData), 64'd16);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
